// File: rtl/alu16_pkg.sv
// rtl/alu16_pkg.sv - opcodes, FSM states and opcode decode shared by the ALU16 arbiter
package alu16_pkg;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_SLT = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic sub;
    logic op1;
    logic op2;
    logic illegal;
  } dec_t;

  // Maps a client opcode onto the ALU16 control pins {Sub, Op1, Op2}.
  function automatic dec_t decode_op(input logic [2:0] op);
    dec_t d;
    d = '0;
    case (op)
      OP_AND: d = '0;
      OP_OR:  d.op2 = 1'b1;
      OP_ADD: d.op1 = 1'b1;
      OP_SUB: begin
        d.sub = 1'b1;
        d.op1 = 1'b1;
      end
      OP_SLT: begin
        d.sub = 1'b1;
        d.op1 = 1'b1;
        d.op2 = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu16_arbiter_rr_arb2.sv
// rtl/alu16_arbiter_rr_arb2.sv - two-way round-robin grant
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant0,
  output logic grant1
);

  // On a tie the requester that was not served last wins.
  assign grant0 = valid0 & (~valid1 | last_grant);
  assign grant1 = valid1 & (~valid0 | ~last_grant);

endmodule

// File: rtl/alu16_arbiter.sv
// rtl/alu16_arbiter.sv - shares one combinational ALU16 between two requesters
module alu16_arbiter
  import alu16_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_f,
  output logic             rsp_cout,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_sub,
  output logic             alu_op1,
  output logic             alu_op2,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             alu_cout
);

  localparam int              CNT_W       = 4;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic               r_last_grant;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_alu_a;
  logic [WIDTH-1:0]   r_alu_b;
  logic               r_alu_sub;
  logic               r_alu_op1;
  logic               r_alu_op2;
  logic               r_rsp_id;
  logic [WIDTH-1:0]   r_rsp_f;
  logic               r_rsp_cout;
  logic               r_rsp_err;

  logic               w_grant0;
  logic               w_grant1;
  logic               w_req0_ready;
  logic               w_req1_ready;
  logic               w_accept;
  logic               w_acc_id;
  logic [2:0]         w_op;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  dec_t               w_dec;

  rr_arb2 u_rr_arb2 (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (r_last_grant),
    .grant0     (w_grant0),
    .grant1     (w_grant1)
  );

  // Grants are one-hot, so grant1 alone selects the winning payload.
  assign w_acc_id = w_grant1;
  assign w_op     = w_grant1 ? req1_op : req0_op;
  assign w_a      = w_grant1 ? req1_a  : req0_a;
  assign w_b      = w_grant1 ? req1_b  : req0_b;
  assign w_dec    = decode_op(w_op);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_req0_ready = 1'b0;
    w_req1_ready = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req0_ready = w_grant0;
        w_req1_ready = w_grant1;
        w_accept     = w_grant0 | w_grant1;
        if (w_accept) begin
          w_next_state = w_dec.illegal ? ST_RESP : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == '0) begin
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_sub    <= 1'b0;
      r_alu_op1    <= 1'b0;
      r_alu_op2    <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_f      <= '0;
      r_rsp_cout   <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_last_grant <= w_acc_id;
            r_rsp_id     <= w_acc_id;
            // Illegal opcodes never touch the ALU pins; the response is synthesised here.
            if (w_dec.illegal) begin
              r_rsp_err  <= 1'b1;
              r_rsp_f    <= '0;
              r_rsp_cout <= 1'b0;
            end else begin
              r_alu_a   <= w_a;
              r_alu_b   <= w_b;
              r_alu_sub <= w_dec.sub;
              r_alu_op1 <= w_dec.op1;
              r_alu_op2 <= w_dec.op2;
              r_cnt     <= SETTLE_LOAD;
            end
          end
        end
        ST_SETTLE: begin
          if (r_cnt == '0) begin
            r_rsp_f    <= alu_f;
            r_rsp_cout <= alu_cout;
            r_rsp_err  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign req0_ready = w_req0_ready;
  assign req1_ready = w_req1_ready;
  assign rsp_valid  = (r_state == ST_RESP);
  assign rsp_id     = r_rsp_id;
  assign rsp_f      = r_rsp_f;
  assign rsp_cout   = r_rsp_cout;
  assign rsp_err    = r_rsp_err;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_sub    = r_alu_sub;
  assign alu_op1    = r_alu_op1;
  assign alu_op2    = r_alu_op2;

endmodule

// File: tb/tb_alu16_arbiter.sv
// tb/tb_alu16_arbiter.sv - self-checking bench for alu16_arbiter with a stand-in ALU16
module tb_alu16_arbiter;

  localparam int SC = 2;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [2:0]  req0_op;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [2:0]  req1_op;
  logic [15:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_err;
  logic [15:0] rsp_f;
  logic [15:0] alu_a, alu_b, alu_f;
  logic        alu_sub, alu_op1, alu_op2, alu_cout;

  alu16_arbiter #(.WIDTH(16), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_f(rsp_f),
    .rsp_cout(rsp_cout), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sub(alu_sub), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_f(alu_f), .alu_cout(alu_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the gate-level ALU16: shared adder with B inversion for Sub.
  logic [15:0] w_bb;
  logic [16:0] w_sum;
  logic        w_ovf;
  always_comb begin
    w_bb  = alu_sub ? ~alu_b : alu_b;
    w_sum = {1'b0, alu_a} + {1'b0, w_bb} + {16'd0, alu_sub};
    w_ovf = (alu_a[15] == w_bb[15]) && (w_sum[15] != alu_a[15]);
    case ({alu_op1, alu_op2})
      2'b00:   alu_f = alu_a & alu_b;
      2'b01:   alu_f = alu_a | alu_b;
      2'b10:   alu_f = w_sum[15:0];
      default: alu_f = {15'd0, w_sum[15] ^ w_ovf};
    endcase
    alu_cout = w_sum[16];
  end

  // Reference from opcode semantics: returns {err, cout, f}.
  function automatic logic [17:0] ref_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int ua, ub, sa, sb, f;
    bit c, e;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    e = 0; c = 0; f = 0;
    case (op)
      3'd0: begin f = ua & ub;              c = (ua + ub) > 65535; end
      3'd1: begin f = ua | ub;              c = (ua + ub) > 65535; end
      3'd2: begin f = (ua + ub) % 65536;    c = (ua + ub) > 65535; end
      3'd3: begin f = (ua - ub + 65536) % 65536; c = ua >= ub; end
      3'd4: begin f = (sa < sb) ? 1 : 0;    c = ua >= ub; end
      default: e = 1;
    endcase
    return {e, c, 16'(f)};
  endfunction

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_op(input bit id, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] f, output logic c, output logic e, output logic rid,
                       output int lat, output logic [2:0] ctrl1, output logic [1:0] rdy1);
    bit got;
    int n;
    @(negedge clk);
    if (id == 0) begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
    else         begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    #1;
    got = 0; n = 0;
    while (!got && n < 50) begin
      if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) got = 1;
      else begin @(negedge clk); #1; n++; end
    end
    if (!got) check("ready_timeout", 0, 1);
    @(negedge clk);
    if (id == 0) req0_valid = 0; else req1_valid = 0;
    #1;
    ctrl1 = {alu_sub, alu_op1, alu_op2};
    rdy1  = {req1_ready, req0_ready};
    lat = 1;
    while (!rsp_valid && lat < 50) begin @(negedge clk); #1; lat++; end
    f = rsp_f; c = rsp_cout; e = rsp_err; rid = rsp_id;
  endtask

  typedef struct {
    bit          id;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] f;
    logic        c;
    logic        e;
  } vec_t;

  vec_t        vecs[10];
  logic [15:0] g_f;
  logic        g_c, g_e, g_id;
  int          g_lat;
  logic [2:0]  g_ctrl;
  logic [1:0]  g_rdy;
  logic [17:0] exp_r;
  int          q_grant[$];
  int          q_rid[$];
  int          q_rf[$];
  int          exp_g[3];
  int          exp_f[3];
  bit          saw;
  bit          rid_r;
  logic [2:0]  op_r;
  logic [15:0] a_r, b_r;

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end

  initial begin
    rsp_ready = 1; req0_op = 0; req0_a = 0; req0_b = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    apply_reset();
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_f", rsp_f, 0);
    check("rst_rsp_cout", rsp_cout, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_alu_ab", {alu_a, alu_b}, 0);
    check("rst_alu_ctrl", {alu_sub, alu_op1, alu_op2}, 0);
    check("rst_ready", {req1_ready, req0_ready}, 0);

    vecs[0] = '{1'b0, 3'd2, 16'd637,   16'd120,   16'd757,   1'b0, 1'b0};
    vecs[1] = '{1'b1, 3'd3, 16'd0,     16'd1,     16'hFFFF,  1'b0, 1'b0};
    vecs[2] = '{1'b0, 3'd4, 16'd0,     16'd1,     16'd1,     1'b0, 1'b0};
    vecs[3] = '{1'b1, 3'd1, 16'd637,   16'd120,   16'd637,   1'b0, 1'b0};
    vecs[4] = '{1'b0, 3'd3, 16'd1,     16'd1,     16'd0,     1'b1, 1'b0};
    vecs[5] = '{1'b1, 3'd2, 16'hFFFF,  16'd1,     16'd0,     1'b1, 1'b0};
    vecs[6] = '{1'b0, 3'd0, 16'hF0F0,  16'h0FF0,  16'h00F0,  1'b1, 1'b0};
    vecs[7] = '{1'b1, 3'd6, 16'd5,     16'd5,     16'd0,     1'b0, 1'b1};
    vecs[8] = '{1'b0, 3'd4, 16'h8000,  16'd1,     16'd1,     1'b1, 1'b0};
    vecs[9] = '{1'b0, 3'd7, 16'd1,     16'd2,     16'd0,     1'b0, 1'b1};

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, g_f, g_c, g_e, g_id, g_lat, g_ctrl, g_rdy);
      check($sformatf("vec%0d_f", i), g_f, vecs[i].f);
      check($sformatf("vec%0d_cout", i), g_c, vecs[i].c);
      check($sformatf("vec%0d_err", i), g_e, vecs[i].e);
      check($sformatf("vec%0d_id", i), g_id, vecs[i].id);
      check($sformatf("vec%0d_lat", i), g_lat, vecs[i].e ? 1 : SC + 1);
      if (i == 0) begin
        check("add_settle_ctrl", g_ctrl, 3'b010);
        check("add_ready_pulse", g_rdy, 2'b00);
      end
    end

    // Illegal op leaves the ALU pins at the previous operation's values.
    do_op(0, 3'd2, 16'h1234, 16'h0101, g_f, g_c, g_e, g_id, g_lat, g_ctrl, g_rdy);
    check("pre_ill_f", g_f, 16'h1335);
    do_op(0, 3'd6, 16'd5, 16'd5, g_f, g_c, g_e, g_id, g_lat, g_ctrl, g_rdy);
    check("ill_lat", g_lat, 1);
    check("ill_err", g_e, 1);
    check("ill_f", g_f, 0);
    check("ill_alu_a", alu_a, 16'h1234);
    check("ill_alu_b", alu_b, 16'h0101);
    check("ill_alu_ctrl", {alu_sub, alu_op1, alu_op2}, 3'b010);

    // Both requesters valid continuously after reset: grants alternate starting at req0.
    apply_reset();
    req0_op = 3'd3; req0_a = 16'd1;   req0_b = 16'd1;
    req1_op = 3'd1; req1_a = 16'd637; req1_b = 16'd120;
    req0_valid = 1; req1_valid = 1;
    #1;
    for (int k = 0; k < 60 && q_rid.size() < 3; k++) begin
      if (req0_ready) q_grant.push_back(0);
      if (req1_ready) q_grant.push_back(1);
      if (rsp_valid) begin q_rid.push_back(int'(rsp_id)); q_rf.push_back(int'(rsp_f)); end
      if (q_rid.size() < 3) begin @(negedge clk); #1; end
    end
    req0_valid = 0; req1_valid = 0;
    exp_g = '{0, 1, 0};
    exp_f = '{0, 637, 0};
    check("alt_grant_count", q_grant.size(), 3);
    check("alt_rsp_count", q_rid.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("alt_grant%0d", i), (i < q_grant.size()) ? q_grant[i] : 9, exp_g[i]);
      check($sformatf("alt_rid%0d", i), (i < q_rid.size()) ? q_rid[i] : 9, exp_g[i]);
      check($sformatf("alt_rf%0d", i), (i < q_rf.size()) ? q_rf[i] : 99999, exp_f[i]);
    end

    // Backpressure: response held for five cycles while req1 waits.
    @(negedge clk);
    rsp_ready = 0;
    req0_valid = 1; req0_op = 3'd2; req0_a = 16'd100; req0_b = 16'd23;
    #1;
    for (int k = 0; k < 50 && !req0_ready; k++) begin @(negedge clk); #1; end
    @(negedge clk);
    req0_valid = 0;
    req1_valid = 1; req1_op = 3'd1; req1_a = 16'd3; req1_b = 16'd4;
    #1;
    for (int k = 0; k < 50 && !rsp_valid; k++) begin @(negedge clk); #1; end
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_valid%0d", k), rsp_valid, 1);
      check($sformatf("bp_f%0d", k), rsp_f, 16'd123);
      check($sformatf("bp_id%0d", k), rsp_id, 0);
      check($sformatf("bp_err%0d", k), rsp_err, 0);
      check($sformatf("bp_req1_ready%0d", k), req1_ready, 0);
      @(negedge clk); #1;
    end
    rsp_ready = 1;
    @(negedge clk); #1;
    check("bp_valid_drop", rsp_valid, 0);
    check("bp_req1_accept", req1_ready, 1);
    @(negedge clk);
    req1_valid = 0;
    #1;
    for (int k = 0; k < 50 && !rsp_valid; k++) begin @(negedge clk); #1; end
    check("bp_req1_f", rsp_f, 16'd7);
    check("bp_req1_id", rsp_id, 1);

    // Reset in SETTLE drops the operation and restores the req0 tie priority.
    @(negedge clk);
    req0_valid = 1; req0_op = 3'd3; req0_a = 16'd9; req0_b = 16'd4;
    #1;
    for (int k = 0; k < 50 && !req0_ready; k++) begin @(negedge clk); #1; end
    @(negedge clk);
    req0_valid = 0;
    #1;
    check("rs_in_settle_ctrl", {alu_sub, alu_op1, alu_op2}, 3'b110);
    rst_n = 0;
    @(negedge clk); #1;
    check("rs_rsp_valid", rsp_valid, 0);
    check("rs_alu_ab", {alu_a, alu_b}, 0);
    check("rs_alu_ctrl", {alu_sub, alu_op1, alu_op2}, 0);
    rst_n = 1;
    saw = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      if (rsp_valid) saw = 1;
    end
    check("rs_no_response", saw, 0);
    @(negedge clk);
    req0_valid = 1; req0_op = 3'd0; req0_a = 16'hFF00; req0_b = 16'h0FF0;
    req1_valid = 1; req1_op = 3'd1; req1_a = 16'd1;    req1_b = 16'd2;
    #1;
    check("rs_tie_ready", {req1_ready, req0_ready}, 2'b01);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    #1;
    for (int k = 0; k < 50 && !rsp_valid; k++) begin @(negedge clk); #1; end
    check("rs_tie_id", rsp_id, 0);
    check("rs_tie_f", rsp_f, 16'h0F00);

    // Randomised operations against the opcode-level reference.
    for (int i = 0; i < 40; i++) begin
      rid_r = 1'($urandom_range(0, 1));
      op_r  = 3'($urandom_range(0, 7));
      a_r   = 16'($urandom);
      b_r   = (i % 5 == 0) ? a_r : 16'($urandom);
      exp_r = ref_model(op_r, a_r, b_r);
      do_op(rid_r, op_r, a_r, b_r, g_f, g_c, g_e, g_id, g_lat, g_ctrl, g_rdy);
      check($sformatf("rnd%0d_f", i), g_f, exp_r[15:0]);
      check($sformatf("rnd%0d_cout", i), g_c, exp_r[16]);
      check($sformatf("rnd%0d_err", i), g_e, exp_r[17]);
      check($sformatf("rnd%0d_id", i), g_id, rid_r);
      check($sformatf("rnd%0d_lat", i), g_lat, exp_r[17] ? 1 : SC + 1);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
